// File: rtl/useq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | useq_pkg : op/state encodings and default sizes for useq_ctrl       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package useq_pkg;

  localparam int AW_DEF = 11;
  localparam int SD_DEF = 4;
  localparam int CW_DEF = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_NEXT  = 3'd0;
  localparam op_t OP_JMP   = 3'd1;
  localparam op_t OP_CJMP  = 3'd2;
  localparam op_t OP_CALL  = 3'd3;
  localparam op_t OP_RET   = 3'd4;
  localparam op_t OP_LDCNT = 3'd5;
  localparam op_t OP_LOOP  = 3'd6;
  localparam op_t OP_RPT2  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/useq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | useq_if : microinstruction-register side bundle of the sequencer   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface useq_if #(
  parameter int AW = 11,
  parameter int SD = 4,
  parameter int CW = 8
);
  localparam int SPW = $clog2(SD + 1);

  logic           start;
  logic           adv;
  logic [2:0]     op;
  logic [AW-1:0]  br_addr;
  logic           cond;
  logic [CW-1:0]  cnt_val;
  logic           clr_err;
  logic [AW-1:0]  upc;
  logic           running;
  logic           fault;
  logic [SPW-1:0] sp;

  modport master (
    output start, adv, op, br_addr, cond, cnt_val, clr_err,
    input  upc, running, fault, sp
  );

  modport slave (
    input  start, adv, op, br_addr, cond, cnt_val, clr_err,
    output upc, running, fault, sp
  );
endinterface
`default_nettype wire

// File: rtl/useq_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | useq_stack : SD-entry return-address LIFO, async reset to empty     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module useq_stack #(
  parameter int AW  = 11,
  parameter int SD  = 4,
  parameter int SPW = $clog2(SD + 1)
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           i_push,
  input  wire logic           i_pop,
  input  wire logic           i_clr,
  input  wire logic [AW-1:0]  i_din,
  output      logic [AW-1:0]  o_top,
  output      logic           o_full,
  output      logic           o_empty,
  output      logic [SPW-1:0] o_sp
);
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;

  logic [AW-1:0]  r_mem [SD];
  logic [SPW-1:0] r_sp;
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_rd_idx;

  assign w_wr_idx = IW'(r_sp);
  assign w_rd_idx = IW'(r_sp - SPW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
      for (int i = 0; i < SD; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_sp <= '0;
    end else if (i_push) begin
      r_mem[w_wr_idx] <= i_din;
      r_sp            <= r_sp + SPW'(1);
    end else if (i_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  assign o_top   = r_mem[w_rd_idx];
  assign o_full  = (r_sp == SPW'(SD));
  assign o_empty = (r_sp == '0);
  assign o_sp    = r_sp;
endmodule
`default_nettype wire

// File: rtl/useq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | useq_ctrl : micro-PC sequencer (branch/call/loop/rewind) with FSM  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int SD = SD_DEF,
  parameter int CW = CW_DEF
) (
  input wire logic clk,
  input wire logic rst,
  useq_if.slave    bus
);
  localparam int SPW = $clog2(SD + 1);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [AW-1:0]  r_upc;
  logic [AW-1:0]  w_upc_nxt;
  logic [AW-1:0]  w_upc_inc;
  logic [AW-1:0]  w_top;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_exec;
  logic           w_push;
  logic           w_pop;
  logic           w_clr;
  logic           w_full;
  logic           w_empty;
  logic           w_ovf;
  logic           w_unf;
  logic [SPW-1:0] w_sp;

  assign w_exec    = (r_state == ST_RUN) && bus.adv;
  assign w_upc_inc = r_upc + AW'(1);
  assign w_ovf     = w_exec && (bus.op == OP_CALL) && w_full;
  assign w_unf     = w_exec && (bus.op == OP_RET) && w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_ovf || w_unf) w_state_nxt = ST_FAULT;
      ST_FAULT: if (bus.clr_err) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.running = (r_state == ST_RUN);
    bus.fault   = (r_state == ST_FAULT);
  end

  // Stack faults leave upc/cnt/stack untouched: the guarded arms below simply don't fire.
  always_comb begin
    w_upc_nxt = r_upc;
    w_cnt_nxt = r_cnt;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clr     = 1'b0;
    if ((r_state == ST_FAULT) && bus.clr_err) begin
      w_upc_nxt = '0;
      w_cnt_nxt = '0;
      w_clr     = 1'b1;
    end else if (w_exec) begin
      case (bus.op)
        OP_JMP:  w_upc_nxt = bus.br_addr;
        OP_CJMP: w_upc_nxt = bus.cond ? bus.br_addr : w_upc_inc;
        OP_CALL: begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_upc_nxt = bus.br_addr;
          end
        end
        OP_RET: begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_upc_nxt = w_top;
          end
        end
        OP_LDCNT: begin
          w_cnt_nxt = bus.cnt_val;
          w_upc_nxt = w_upc_inc;
        end
        OP_LOOP: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
            w_upc_nxt = bus.br_addr;
          end else begin
            w_upc_nxt = w_upc_inc;
          end
        end
        OP_RPT2: w_upc_nxt = r_upc - AW'(2);
        default: w_upc_nxt = w_upc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc <= '0;
      r_cnt <= '0;
    end else begin
      r_upc <= w_upc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  useq_stack #(
    .AW  (AW),
    .SD  (SD),
    .SPW (SPW)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .i_din   (w_upc_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_sp    (w_sp)
  );

  assign bus.upc = r_upc;
  assign bus.sp  = w_sp;
endmodule
`default_nettype wire

// File: tb/tb_useq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_useq_ctrl : directed + random check of useq_ctrl vs queue model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_useq_ctrl;
  localparam int AW = 11;
  localparam int SD = 4;
  localparam int CW = 8;
  localparam int AMOD = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  useq_if #(.AW(AW), .SD(SD), .CW(CW)) bus ();

  useq_ctrl #(.AW(AW), .SD(SD), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: 0=idle 1=run 2=fault, addresses as plain ints, stack as a queue.
  int m_state;
  int m_upc;
  int m_cnt;
  int m_stk[$];

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_upc   = 0;
    m_cnt   = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input int op, input int br, input bit cnd, input int cv,
                            input bit adv, input bit st, input bit clr);
    case (m_state)
      0: if (st) m_state = 1;
      1: if (adv) begin
        case (op)
          0: m_upc = (m_upc + 1) % AMOD;
          1: m_upc = br;
          2: m_upc = cnd ? br : (m_upc + 1) % AMOD;
          3: if (m_stk.size() == SD) m_state = 2;
             else begin
               m_stk.push_back((m_upc + 1) % AMOD);
               m_upc = br;
             end
          4: if (m_stk.size() == 0) m_state = 2;
             else m_upc = m_stk.pop_back();
          5: begin m_cnt = cv; m_upc = (m_upc + 1) % AMOD; end
          6: if (m_cnt != 0) begin m_cnt--; m_upc = br; end
             else m_upc = (m_upc + 1) % AMOD;
          default: m_upc = (m_upc + AMOD - 2) % AMOD;
        endcase
      end
      default: if (clr) model_reset();
    endcase
  endtask

  task automatic step(input int op, input int br = 0, input bit cnd = 0, input int cv = 0,
                      input bit adv = 1, input bit st = 0, input bit clr = 0);
    @(negedge clk);
    bus.op      = op[2:0];
    bus.br_addr = br[AW-1:0];
    bus.cond    = cnd;
    bus.cnt_val = cv[CW-1:0];
    bus.adv     = adv;
    bus.start   = st;
    bus.clr_err = clr;
    @(posedge clk);
    model_step(op, br, cnd, cv, adv, st, clr);
    #1;
  endtask

  // Hand-computed values pin both the DUT and the model.
  task automatic pin(input string tag, input int upc, input int sp, input int run, input int flt);
    chk({tag, ".upc"}, int'(bus.upc), upc);
    chk({tag, ".sp"}, int'(bus.sp), sp);
    chk({tag, ".running"}, int'(bus.running), run);
    chk({tag, ".fault"}, int'(bus.fault), flt);
    chk({tag, ".model_upc"}, m_upc, upc);
    chk({tag, ".model_sp"}, m_stk.size(), sp);
  endtask

  task automatic clear_inputs();
    bus.op = '0; bus.br_addr = '0; bus.cond = 1'b0; bus.cnt_val = '0;
    bus.adv = 1'b0; bus.start = 1'b0; bus.clr_err = 1'b0;
  endtask

  // Raise rst a few ns after an edge and check outputs before the next edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    pin(tag, 0, 0, 0, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("cmp.upc", int'(bus.upc), m_upc);
      chk("cmp.sp", int'(bus.sp), m_stk.size());
      chk("cmp.running", int'(bus.running), int'(m_state == 1));
      chk("cmp.fault", int'(bus.fault), int'(m_state == 2));
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    pin("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    step(0, 0, 0, 0, 1, 1);
    pin("start", 0, 0, 1, 0);
    step(0); step(0); step(0);
    pin("next3", 3, 0, 1, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    pin("hold", 3, 0, 1, 0);

    step(2, 'h100, 0);            pin("cjmp0", 4, 0, 1, 0);
    step(2, 'h100, 1);            pin("cjmp1", 'h100, 0, 1, 0);
    step(1, 'h7FF);               pin("jmp", 'h7FF, 0, 1, 0);
    step(0);                      pin("wrap", 0, 0, 1, 0);

    step(1, 'h010);
    step(3, 'h200);               pin("call1", 'h200, 1, 1, 0);
    step(3, 'h300);               pin("call2", 'h300, 2, 1, 0);
    step(4);                      pin("ret1", 'h201, 1, 1, 0);
    step(4);                      pin("ret2", 'h011, 0, 1, 0);

    for (int i = 0; i < 4; i++) step(3, 'h400);
    pin("full", 'h400, 4, 1, 0);
    step(3, 'h500);               pin("ovf", 'h400, 4, 0, 1);
    step(0);                      pin("frozen", 'h400, 4, 0, 1);
    step(0, 0, 0, 0, 1, 1);       pin("start_in_fault", 'h400, 4, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);    pin("clr", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(4);                      pin("unf", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    step(1, 'h020);
    step(5, 0, 0, 2);             pin("ldcnt", 'h021, 0, 1, 0);
    step(0);                      pin("body", 'h022, 0, 1, 0);
    step(6, 'h021);               pin("loop1", 'h021, 0, 1, 0);
    step(0);
    step(6, 'h021);               pin("loop2", 'h021, 0, 1, 0);
    step(0);
    step(6, 'h021);               pin("loopexit", 'h023, 0, 1, 0);
    chk("model_cnt", m_cnt, 0);
    step(6, 'h021);               pin("loop_cnt0", 'h024, 0, 1, 0);

    step(1, 'h005);
    step(7);                      pin("rpt2", 'h003, 0, 1, 0);
    step(1, 'h001);
    step(7);                      pin("rpt2wrap", 'h7FF, 0, 1, 0);

    step(3, 'h123); step(3, 'h234);
    pin("pre_rst", 'h234, 2, 1, 0);
    mid_reset("async_rst");

    for (int i = 0; i < 3000; i++) begin
      int op, br, cv;
      bit adv, st, clr, cnd;
      op  = $urandom_range(0, 7);
      adv = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 5) == 0);
      cnd = $urandom_range(0, 1);
      cv  = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0: br = 0;
        1: br = 1;
        2: br = AMOD - 1;
        3: br = AMOD - 2;
        default: br = $urandom_range(0, AMOD - 1);
      endcase
      step(op, br, cnd, cv, adv, st, clr);
      if ($urandom_range(0, 499) == 0) mid_reset("rand_rst");
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
